// File: rtl/btb_ras_predictor_pkg.sv
// Shared encodings and entry layout for the BTB + return-address-stack fetch predictor.
package btb_ras_predictor_pkg;

  localparam int unsigned PC_W_DEFAULT  = 32;
  localparam int unsigned TAG_W_DEFAULT = 20;

  typedef enum logic [1:0] {
    JT_NONE = 2'b00,
    JT_JUMP = 2'b01,
    JT_CALL = 2'b10,
    JT_RET  = 2'b11
  } jtype_e;

  typedef struct packed {
    logic                     valid;
    logic [TAG_W_DEFAULT-1:0] tag;
    logic [PC_W_DEFAULT-1:0]  target;
    jtype_e                   jtype;
  } btb_entry_t;

endpackage

// File: rtl/btb_ras_predictor_if.sv
// Fetch-side lookup, ID-side training and RAS recovery bundle for btb_ras_predictor.
interface btb_ras_predictor_if
  import btb_ras_predictor_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  parameter int unsigned PTR_W = 4
);
  logic             lookup_valid;
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_hit;
  logic [PC_W-1:0]  pred_target;
  jtype_e           pred_type;
  logic [PTR_W-1:0] ras_ckpt_ptr;
  logic [PTR_W:0]   ras_ckpt_cnt;
  logic             update_valid;
  logic [PC_W-1:0]  update_pc;
  logic [PC_W-1:0]  update_target;
  jtype_e           update_type;
  logic             recover_valid;
  logic [PTR_W-1:0] recover_ptr;
  logic [PTR_W:0]   recover_cnt;

  modport master (
    output lookup_valid, lookup_pc, update_valid, update_pc, update_target, update_type,
    output recover_valid, recover_ptr, recover_cnt,
    input  pred_hit, pred_target, pred_type, ras_ckpt_ptr, ras_ckpt_cnt
  );

  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_target, update_type,
    input  recover_valid, recover_ptr, recover_cnt,
    output pred_hit, pred_target, pred_type, ras_ckpt_ptr, ras_ckpt_cnt
  );
endinterface

// File: rtl/btb_ras_predictor_ras_stack.sv
// Circular return-address stack with saturating occupancy and pointer/count recovery.
module btb_ras_predictor_ras_stack #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_addr,
  input  logic             recover,
  input  logic [PTR_W-1:0] recover_ptr,
  input  logic [PTR_W:0]   recover_cnt,
  output logic [PC_W-1:0]  top,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W:0]   cnt
);

  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [PTR_W:0]   cnt_q, cnt_d;

  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (recover) begin
      ptr_d = recover_ptr;
      cnt_d = recover_cnt;
    end else if (push) begin
      // Wrapping onto the oldest slot is intentional; occupancy just saturates.
      ptr_d = ptr_inc;
      if (cnt_q != Full) cnt_d = cnt_q + (PTR_W + 1)'(1);
    end else if (pop && cnt_q != '0) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !recover) mem_q[ptr_q] <= push_addr;
  end

  assign top = mem_q[ptr_dec];
  assign ptr = ptr_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/btb_ras_predictor.sv
// 2-way set-associative BTB with per-set LRU, paired with a checkpointable RAS.
module btb_ras_predictor
  import btb_ras_predictor_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEFAULT,
  parameter int unsigned SETS      = 128,
  parameter int unsigned TAG_W     = TAG_W_DEFAULT,
  parameter int unsigned RAS_DEPTH = 16,
  localparam int unsigned IDX_W    = $clog2(SETS),
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH)
) (
  input logic                clock,
  input logic                reset,
  btb_ras_predictor_if.slave bus
);

  logic [TAG_W-1:0] tag_q    [SETS][2];
  logic [PC_W-1:0]  target_q [SETS][2];
  jtype_e           type_q   [SETS][2];
  logic [1:0]       valid_q  [SETS];
  logic [SETS-1:0]  lru_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [1:0]       lk_match, up_match;
  logic             lk_hit, lk_way, tr_en, tr_way;
  jtype_e           hit_type;
  logic [PC_W-1:0]  hit_target, ras_top;
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W:0]   ras_cnt;
  logic             pred_hit, ras_push, ras_pop;
  logic [PC_W-1:0]  pred_target;
  jtype_e           pred_type;
  logic             unused_pc;

  // Low offset bits and bits above the tag do not participate in the lookup.
  assign unused_pc = ^{bus.lookup_pc, bus.update_pc};

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign up_idx = bus.update_pc[IDX_W+1:2];
  assign up_tag = bus.update_pc[IDX_W+1+TAG_W:IDX_W+2];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
      up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
    end
  end

  assign lk_hit     = |lk_match;
  assign lk_way     = ~lk_match[0];
  assign hit_type   = type_q[lk_idx][lk_way];
  assign hit_target = target_q[lk_idx][lk_way];

  always_comb begin
    pred_hit    = 1'b0;
    pred_target = '0;
    pred_type   = JT_NONE;
    if (lk_hit) begin
      pred_type = hit_type;
      case (hit_type)
        JT_JUMP, JT_CALL: begin
          pred_hit    = 1'b1;
          pred_target = hit_target;
        end
        JT_RET: begin
          if (ras_cnt != '0) begin
            pred_hit    = 1'b1;
            pred_target = ras_top;
          end
        end
        default: ;
      endcase
    end
  end

  assign ras_push = bus.lookup_valid && pred_hit && (hit_type == JT_CALL);
  assign ras_pop  = bus.lookup_valid && pred_hit && (hit_type == JT_RET);

  // Training prefers an in-place overwrite, then a free way, then the LRU victim.
  assign tr_en = bus.update_valid && (bus.update_type != JT_NONE);
  always_comb begin
    if (up_match[0])                  tr_way = 1'b0;
    else if (up_match[1])             tr_way = 1'b1;
    else if (!valid_q[up_idx][0])     tr_way = 1'b0;
    else if (!valid_q[up_idx][1])     tr_way = 1'b1;
    else                              tr_way = lru_q[up_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else begin
      if (bus.lookup_valid && lk_hit) lru_q[lk_idx] <= ~lk_way;
      // Later assignment lets training win a same-set LRU conflict.
      if (tr_en) begin
        valid_q[up_idx][tr_way] <= 1'b1;
        lru_q[up_idx]           <= ~tr_way;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tr_en) begin
      tag_q[up_idx][tr_way]    <= up_tag;
      target_q[up_idx][tr_way] <= bus.update_target;
      type_q[up_idx][tr_way]   <= bus.update_type;
    end
  end

  btb_ras_predictor_ras_stack #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .push        (ras_push),
    .pop         (ras_pop),
    .push_addr   (bus.lookup_pc + PC_W'(4)),
    .recover     (bus.recover_valid),
    .recover_ptr (bus.recover_ptr),
    .recover_cnt (bus.recover_cnt),
    .top         (ras_top),
    .ptr         (ras_ptr),
    .cnt         (ras_cnt)
  );

  assign bus.pred_hit     = pred_hit;
  assign bus.pred_target  = pred_target;
  assign bus.pred_type    = pred_type;
  assign bus.ras_ckpt_ptr = ras_ptr;
  assign bus.ras_ckpt_cnt = ras_cnt;

endmodule

// File: tb/tb_btb_ras_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a recency-list model.
module tb_btb_ras_predictor;
  import btb_ras_predictor_pkg::*;

  localparam int unsigned SETS  = 128;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned IDX_W = 7;
  localparam int unsigned TAG_W = 20;

  localparam logic [31:0] PC_A    = 32'h8000_0010;
  localparam logic [31:0] PC_B    = 32'h8000_0210;
  localparam logic [31:0] PC_C    = 32'h8000_0410;
  localparam logic [31:0] PC_CALL = 32'h8000_0020;
  localparam logic [31:0] PC_RET  = 32'h8000_0200;
  localparam logic [31:0] PC_OVF  = 32'h8000_1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  btb_ras_predictor_if #(.PC_W(32), .PTR_W(PTR_W)) bus ();

  btb_ras_predictor #(
    .PC_W      (32),
    .SETS      (SETS),
    .TAG_W     (TAG_W),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Each set is a recency list: front is least recently touched (the victim).
  btb_entry_t  mdl_set [SETS][$];
  logic [31:0] mdl_ras [DEPTH];
  int          mdl_ptr, mdl_cnt;
  int          hist_ptr[$], hist_cnt[$];
  logic        exp_hit;
  logic [31:0] exp_target;
  jtype_e      exp_type;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

  function automatic int find_tag(input int s, input logic [TAG_W-1:0] t);
    for (int i = 0; i < mdl_set[s].size(); i++) if (mdl_set[s][i].tag == t) return i;
    return -1;
  endfunction

  task automatic predict(input logic [31:0] pc);
    int s, i;
    s = pc_idx(pc);
    i = find_tag(s, pc_tag(pc));
    exp_hit    = 1'b0;
    exp_target = '0;
    exp_type   = JT_NONE;
    if (i >= 0) begin
      exp_type = mdl_set[s][i].jtype;
      if (exp_type != JT_RET) begin
        exp_hit    = 1'b1;
        exp_target = mdl_set[s][i].target;
      end else if (mdl_cnt > 0) begin
        exp_hit    = 1'b1;
        exp_target = mdl_ras[(mdl_ptr + DEPTH - 1) % DEPTH];
      end
    end
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < SETS; s++) mdl_set[s].delete();
    mdl_ptr = 0;
    mdl_cnt = 0;
    hist_ptr.delete();
    hist_cnt.delete();
  endtask

  task automatic mdl_edge();
    int ls, li, us, ui;
    logic do_train, have_victim;
    logic [TAG_W-1:0] utag, victim_tag;
    btb_entry_t ne;
    ls = pc_idx(bus.lookup_pc);
    li = find_tag(ls, pc_tag(bus.lookup_pc));
    predict(bus.lookup_pc);
    if (bus.recover_valid) begin
      mdl_ptr = int'(bus.recover_ptr);
      mdl_cnt = int'(bus.recover_cnt);
    end else if (bus.lookup_valid && exp_hit) begin
      if (exp_type == JT_CALL) begin
        mdl_ras[mdl_ptr] = bus.lookup_pc + 32'd4;
        mdl_ptr = (mdl_ptr + 1) % DEPTH;
        if (mdl_cnt < DEPTH) mdl_cnt++;
      end else if (exp_type == JT_RET) begin
        mdl_ptr = (mdl_ptr + DEPTH - 1) % DEPTH;
        mdl_cnt--;
      end
    end
    // Victim is chosen from the state before this edge's lookup touch.
    do_train    = bus.update_valid && (bus.update_type != JT_NONE);
    us          = pc_idx(bus.update_pc);
    utag        = pc_tag(bus.update_pc);
    have_victim = 1'b0;
    victim_tag  = '0;
    if (do_train && find_tag(us, utag) < 0 && mdl_set[us].size() == 2) begin
      have_victim = 1'b1;
      victim_tag  = mdl_set[us][0].tag;
    end
    if (bus.lookup_valid && li >= 0) begin
      ne = mdl_set[ls][li];
      mdl_set[ls].delete(li);
      mdl_set[ls].push_back(ne);
    end
    if (do_train) begin
      ui = find_tag(us, utag);
      if (ui >= 0) mdl_set[us].delete(ui);
      else if (have_victim) mdl_set[us].delete(find_tag(us, victim_tag));
      ne.valid  = 1'b1;
      ne.tag    = utag;
      ne.target = bus.update_target;
      ne.jtype  = bus.update_type;
      mdl_set[us].push_back(ne);
    end
  endtask

  task automatic idle();
    bus.lookup_valid  = 1'b0;
    bus.lookup_pc     = '0;
    bus.update_valid  = 1'b0;
    bus.update_pc     = '0;
    bus.update_target = '0;
    bus.update_type   = JT_NONE;
    bus.recover_valid = 1'b0;
    bus.recover_ptr   = '0;
    bus.recover_cnt   = '0;
  endtask

  task automatic look();
    @(negedge clock);
    predict(bus.lookup_pc);
    check("pred_hit", bus.pred_hit, exp_hit);
    check("pred_type", bus.pred_type, exp_type);
    check("pred_target", bus.pred_target, exp_target);
    check("ckpt_ptr", bus.ras_ckpt_ptr, mdl_ptr);
    check("ckpt_cnt", bus.ras_ckpt_cnt, mdl_cnt);
  endtask

  task automatic advance();
    @(posedge clock);
    mdl_edge();
    #1;
    idle();
  endtask

  task automatic tick();
    look();
    advance();
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input jtype_e ty);
    bus.update_valid  = 1'b1;
    bus.update_pc     = pc;
    bus.update_target = tgt;
    bus.update_type   = ty;
    tick();
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h8000_0000 | ($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 2);
  endfunction

  initial begin
    idle();
    bus.lookup_pc = PC_A;
    #2 reset = 1'b0;
    mdl_reset();
    look();
    check("rst_hit", bus.pred_hit, 1'b0);
    check("rst_cnt", bus.ras_ckpt_cnt, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Cold start, then a trained jump hits next cycle.
    bus.lookup_pc = PC_A;
    look();
    check("cold_hit", bus.pred_hit, 1'b0);
    check("cold_type", bus.pred_type, JT_NONE);
    advance();
    train(PC_A, 32'h8000_0100, JT_JUMP);
    bus.lookup_pc = PC_A;
    look();
    check("warm_hit", bus.pred_hit, 1'b1);
    check("warm_target", bus.pred_target, 32'h8000_0100);
    advance();

    // Set 4: A, B, touch A, then C must evict B.
    train(PC_B, 32'h8000_0300, JT_JUMP);
    fetch(PC_A);
    train(PC_C, 32'h8000_0500, JT_JUMP);
    bus.lookup_pc = PC_B;
    look();
    check("evict_b", bus.pred_hit, 1'b0);
    advance();
    bus.lookup_pc = PC_A;
    look();
    check("keep_a", bus.pred_hit, 1'b1);
    advance();
    bus.lookup_pc = PC_C;
    look();
    check("keep_c", bus.pred_hit, 1'b1);
    advance();

    // Call then return.
    train(PC_CALL, 32'h8000_0400, JT_CALL);
    train(PC_RET, 32'h0, JT_RET);
    fetch(PC_CALL);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = PC_RET;
    look();
    check("call_cnt", bus.ras_ckpt_cnt, 1);
    check("ret_target", bus.pred_target, 32'h8000_0024);
    advance();
    look();
    check("ret_cnt", bus.ras_ckpt_cnt, 0);
    advance();

    // Return with an empty stack.
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = PC_RET;
    look();
    check("uflow_hit", bus.pred_hit, 1'b0);
    advance();
    look();
    check("uflow_ptr", bus.ras_ckpt_ptr, 0);
    check("uflow_cnt", bus.ras_ckpt_cnt, 0);
    advance();

    // Overflow: DEPTH+2 calls, then DEPTH returns in LIFO order.
    for (int i = 0; i < DEPTH + 2; i++) train(PC_OVF + 32'(4 * i), 32'h9000_0000, JT_CALL);
    for (int i = 0; i < DEPTH + 2; i++) fetch(PC_OVF + 32'(4 * i));
    look();
    check("ovf_cnt", bus.ras_ckpt_cnt, DEPTH);
    check("ovf_ptr", bus.ras_ckpt_ptr, 2);
    advance();
    for (int k = 0; k < DEPTH; k++) begin
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = PC_RET;
      look();
      check("ovf_ret", bus.pred_target, PC_OVF + 32'(4 * (DEPTH + 1 - k)) + 32'd4);
      advance();
    end

    // Reset asserted mid-stream clears the prediction immediately.
    fetch(PC_CALL);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = PC_CALL;
    look();
    check("pre_rst_hit", bus.pred_hit, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_hit", bus.pred_hit, 1'b0);
    check("mid_rst_target", bus.pred_target, 0);
    check("mid_rst_cnt", bus.ras_ckpt_cnt, 0);
    mdl_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    idle();

    // Checkpoint at 3/3, push twice, recover in the same cycle as a call.
    train(PC_CALL, 32'h8000_0400, JT_CALL);
    for (int i = 0; i < 3; i++) fetch(PC_CALL);
    look();
    check("ckpt_ptr3", bus.ras_ckpt_ptr, 3);
    check("ckpt_cnt3", bus.ras_ckpt_cnt, 3);
    advance();
    fetch(PC_CALL);
    fetch(PC_CALL);
    bus.lookup_valid  = 1'b1;
    bus.lookup_pc     = PC_CALL;
    bus.recover_valid = 1'b1;
    bus.recover_ptr   = PTR_W'(3);
    bus.recover_cnt   = (PTR_W + 1)'(3);
    tick();
    look();
    check("rcv_ptr", bus.ras_ckpt_ptr, 3);
    check("rcv_cnt", bus.ras_ckpt_cnt, 3);
    advance();

    // Random mix of fetches, training and recoveries on a few crowded sets.
    for (int c = 0; c < 600; c++) begin
      bus.lookup_valid = ($urandom_range(0, 3) != 0);
      bus.lookup_pc    = rand_pc();
      if ($urandom_range(0, 2) == 0) begin
        bus.update_valid  = 1'b1;
        bus.update_pc     = rand_pc();
        bus.update_target = $urandom & 32'hFFFF_FFFC;
        bus.update_type   = jtype_e'($urandom_range(0, 3));
      end
      if (hist_ptr.size() > 0 && $urandom_range(0, 9) == 0) begin
        int k;
        k = $urandom_range(0, hist_ptr.size() - 1);
        bus.recover_valid = 1'b1;
        bus.recover_ptr   = PTR_W'(hist_ptr[k]);
        bus.recover_cnt   = (PTR_W + 1)'(hist_cnt[k]);
      end
      tick();
      hist_ptr.push_back(mdl_ptr);
      hist_cnt.push_back(mdl_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/btb_ras_predictor.md
Name: btb_ras_predictor

Overview:
- Next-generation fetch-stage target predictor: parametrised 2-way set-associative BTB plus circular return-address stack (RAS).
- BTB entries carry partial tags, valid bits and per-set LRU; RAS supports checkpoint/recover so ID/EX mispredict redirects restore the stack pointer.
- Sits beside the IF PC register; lookup is same-cycle combinational, training comes from ID.

Parameters:
- PC_W, 32, PC width in bits.
- SETS, 128, BTB sets (power of 2); IDX_W = log2(SETS).
- TAG_W, 20, partial tag width; requires IDX_W+2+TAG_W <= PC_W.
- RAS_DEPTH, 16, RAS entries (power of 2); PTR_W = log2(RAS_DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  IF fetch is real this cycle (enables RAS side effects).
- lookup_pc  in  PC_W  fetch PC.
- pred_hit  out  1  predicted taken with valid target.
- pred_target  out  PC_W  predicted next PC.
- pred_type  out  2  type of hit entry (01 jump/branch, 10 call, 11 ret; 00 on miss).
- ras_ckpt_ptr  out  PTR_W  RAS pointer before this cycle's push/pop.
- ras_ckpt_cnt  out  PTR_W+1  RAS occupancy before this cycle's push/pop.
- update_valid  in  1  train BTB this cycle.
- update_pc  in  PC_W  PC of resolved control-flow instruction.
- update_target  in  PC_W  resolved target.
- update_type  in  2  01/10/11 as above; 00 ignored even when update_valid=1.
- recover_valid  in  1  restore RAS from checkpoint.
- recover_ptr  in  PTR_W  checkpointed pointer.
- recover_cnt  in  PTR_W+1  checkpointed occupancy.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W : IDX_W+2]. Aliasing from partial tags is accepted.
- Reset (reset=0, async): all valid bits 0, all LRU bits 0, ras_ptr 0, ras_cnt 0.
  - Target/tag arrays are not reset.
  - Outputs during reset: pred_hit 0, pred_type 00, pred_target 0, ckpt outputs 0.
- Lookup (combinational, zero latency): way hit = valid & tag match.
  - On a hit, pred_type is the entry type.
  - Type 01/10: pred_target = stored target, pred_hit = 1.
  - Type 11 with ras_cnt>0: pred_target = RAS[ras_ptr-1], pred_hit = 1.
  - Type 11 with ras_cnt==0: pred_hit = 0, pred_target = 0.
  - On a miss: pred_hit 0, pred_target 0, pred_type 00.
- RAS sequential ops, applied at the clock edge only when lookup_valid & pred_hit & !recover_valid:
  - call: RAS[ras_ptr] <= lookup_pc+4; ras_ptr+1 (mod RAS_DEPTH); ras_cnt = min(ras_cnt+1, RAS_DEPTH). Overflow silently overwrites the oldest entry.
  - ret: ras_ptr-1 (mod RAS_DEPTH); ras_cnt-1.
- Recover: recover_valid=1 loads ras_ptr/ras_cnt from the recover_* inputs and suppresses that cycle's push/pop. Entry contents are not restored; overwritten slots stay lost.
- LRU bit per set (points to the victim way):
  - Lookup hit with lookup_valid sets LRU to the other way.
  - A training write sets LRU to the other way.
  - Same-cycle same-set conflict: the update wins.
- Training (update_valid & update_type!=00), written at the clock edge:
  - Tag match in the set: overwrite that way in place.
  - No match: write the first invalid way (way0 first); else write the LRU way.
  - Written entry gets valid=1, tag, target, type.
- Lookup and update in the same cycle to the same set: lookup sees pre-update contents (no bypass).
- Reset asserted mid-operation clears state immediately; the first edge after release behaves as a fresh start.

Decomposition:
- Shared package holds:
  - Type encodings: JT_NONE=00, JT_JUMP=01, JT_CALL=10, JT_RET=11.
  - Entry struct {valid, tag, target, type}.
  - Default PC_W.
- One sub-module, ras_stack, owns:
  - Circular storage and pointer/count logic.
  - push/pop/recover inputs.
  - top/ptr/cnt outputs.
- BTB arrays, LRU and hit logic stay in the top.

Test Plan:
- Cold start: after reset, lookup_pc=0x80000010 -> pred_hit 0, pred_type 00. Then update pc=0x80000010, target 0x80000100, type 01; next cycle lookup -> hit, target 0x80000100.
- Way replacement: train three PCs mapping to set 4 with distinct tags (A, then B, then lookup A, then C) -> C evicts B; A and C hit, B misses.
- Call/ret: train call at 0x80000020, ret at 0x80000200. Lookup the call -> ras_cnt 1. Lookup the ret -> pred_target 0x80000024, ras_cnt 0.
- Underflow: with ras_cnt 0, lookup a trained ret -> pred_hit 0; ptr and cnt unchanged.
- Overflow: RAS_DEPTH+2 calls from distinct PCs -> ras_cnt saturates at RAS_DEPTH. The following RAS_DEPTH rets return the newest RAS_DEPTH addresses in LIFO order.
- Recover: capture ckpt (ptr 3, cnt 3), perform two calls, then recover_valid with ptr 3/cnt 3 in the same cycle as a call lookup -> no push, ptr 3, cnt 3. Asserting reset low mid-stream clears pred_hit within the same cycle.
